idp_mdu_gen2: RTL and testbench
===============================

Name: idp_mdu_gen2

Overview:
- Second-generation integer datapath for the multi-cycle MIPS core.
- Contains a parametrised register file with R0 forced to zero, the scratch registers RS/RT/ALU_out/D_in, the DA/T/Y selection muxes, and a combinational single-cycle ALU.
- Adds an iterative multiply/divide unit (MDU) with a start/busy/done handshake. The MDU writes HI/LO, replacing the old single-cycle HI/LO load path.
- Sits between the control unit (CU) and the instruction/data memory interfaces.

Parameters:
- DATA_W, 32, datapath width in bits; must be even and ≥ 8.
- RF_AW, 5, register file address width; depth = 2**RF_AW.
- RA_IDX, 2**RF_AW-1, register index selected by DA_Sel=2 (return address).
- SP_IDX, 2**RF_AW-3, register index selected by DA_Sel=3 (stack pointer).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- D_En  in  1  register-file write enable
- DA_Sel  in  2  destination select: 0=D_Addr, 1=T_Addr, 2=RA_IDX, 3=SP_IDX
- T_Sel  in  1  RT scratch input select: 1=DT, 0=regfile T
- Y_Sel  in  3  output select: 0=alu_out, 1=HI, 2=LO, 3=d_in, 4=pc_in, others=alu_out
- FS  in  5  ALU/MDU function select
- shamt  in  5  shift amount; only bits [log2(DATA_W)-1:0] are used
- D_Addr, S_Addr, T_Addr  in  RF_AW  register addresses
- DT, DY, pc_in  in  DATA_W  immediate, memory read data, PC
- md_start  in  1  starts the MDU operation selected by FS, using rs/rt
- md_busy  out  1  MDU operation in progress
- md_done  out  1  one-cycle pulse when HI/LO have been written
- C, V, N, Z  out  1  ALU flags
- ALU_OUT, D_OUT  out  DATA_W  Y-mux output; D_OUT = rt

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all registers, RS, RT, ALU_out, D_in, HI and LO to 0;
  - the MDU state to IDLE, so md_busy=0 and md_done=0.
- Register file:
  - Reads are combinational.
  - Writes occur on the clk edge when D_En=1, writing ALU_OUT into the DA-muxed address.
  - A write to R0 is discarded; R0 always reads 0.
  - On a same-cycle read of the address being written, the old value is read.
- Scratch registers load every edge: RS<=S, RT<=T_Sel?DT:T, ALU_out<=ALU lo result, D_in<=DY.
- ALU is combinational on rs and rt:
  - FS codes: 00 PASS_S, 01 PASS_T, 02 ADD, 03 ADDU, 04 SUB, 05 SUBU, 06 SLT, 07 SLTU, 08 AND, 09 OR, 0A XOR, 0B NOR, 0C SLL, 0D SRL, 0E SRA, 0F LUI (T << DATA_W/2).
  - C and V are meaningful only for 02–05; they are 0 for all other codes.
  - N = result MSB; Z = (result == 0).
- MDU FS codes: 10 MULT, 11 MULTU, 12 DIV, 13 DIVU. Any other FS with md_start=1 is ignored.
- MDU states:
  - IDLE:
    - md_start=1 with a valid FS captures rs, rt and the op, latches the sign corrections, loads count=DATA_W, and moves to RUN.
  - RUN:
    - One radix-2 shift-add or restoring-subtract step per cycle.
    - When count reaches 1, moves to FIX.
  - FIX:
    - Applies the result sign and writes HI/LO.
    - md_done=1 for the following cycle; returns to IDLE.
- md_busy=1 while the state is RUN or FIX.
- Latency: with md_start sampled at edge E0, HI/LO update at edge E(DATA_W+1) and md_done is high during the cycle after that edge.
  - DATA_W=32 gives 33 edges.
- md_start while busy is ignored; there is no queueing.
- Reading HI/LO while busy returns the previous values; there is no interlock, and the CU waits for md_done.
- MULT/MULTU: {HI,LO} = full 2·DATA_W-bit product.
- DIV/DIVU:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend.
  - Divide by zero uses the same latency and raises no flag.
- Signed overflow case (min / -1): LO = min, HI = 0.
- Reset mid-operation: the MDU aborts immediately, HI/LO = 0, and no md_done is produced.

Decomposition:
- Shared package idp_pkg holds:
  - FS code constants;
  - Y_Sel and DA_Sel encodings;
  - MDU state enum (IDLE/RUN/FIX).
- Sub-module mdu_iter (parametrised DATA_W) contains the MDU state machine, counter, sign fixup and HI/LO registers.
- The register file, scratch registers, ALU and muxes stay in the top module.

Test Plan:
- DATA_W=32, MULT rs=0xFFFFFFFD (−3), rt=5 -> after 33 edges md_done pulses; HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_busy high for exactly 33 cycles.
- DIVU 100/7 -> LO=14, HI=2. DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/−1 -> LO=0x80000000, HI=0.
- DIV 1234/0 -> LO=0xFFFFFFFF, HI=1234. Then a second md_start pulsed mid-operation (while busy) -> ignored; exactly one md_done.
- Write 0xDEADBEEF with D_Addr=0 and D_En=1 -> R0 reads 0. DA_Sel=2 and DA_Sel=3 write regs 31 and 29. RF_AW=4 build -> writes go to 15 and 13.
- ADD 0x7FFFFFFF+1 -> V=1, N=1, C=0. SUBU 0−1 -> C=0, Z=0 (C defined as no-borrow). SRA 0x80000000 by 4 -> 0xF8000000.
- Assert reset at cycle 10 of a MULTU -> immediately md_busy=0 and HI=LO=0; no md_done follows. A new MULTU 0xFFFFFFFF² -> HI=0xFFFFFFFE, LO=1.

Source files
------------

// File: rtl/idp_pkg.sv
// Shared definitions for the gen2 integer datapath.
// Holds the ALU/MDU function-select codes, the Y_Sel and DA_Sel mux
// encodings, the MDU state enum and a helper that recognises MDU opcodes.
package idp_pkg;

  // ALU function codes
  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_PASS_T = 5'h01;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_ADDU   = 5'h03;
  localparam logic [4:0] FS_SUB    = 5'h04;
  localparam logic [4:0] FS_SUBU   = 5'h05;
  localparam logic [4:0] FS_SLT    = 5'h06;
  localparam logic [4:0] FS_SLTU   = 5'h07;
  localparam logic [4:0] FS_AND    = 5'h08;
  localparam logic [4:0] FS_OR     = 5'h09;
  localparam logic [4:0] FS_XOR    = 5'h0A;
  localparam logic [4:0] FS_NOR    = 5'h0B;
  localparam logic [4:0] FS_SLL    = 5'h0C;
  localparam logic [4:0] FS_SRL    = 5'h0D;
  localparam logic [4:0] FS_SRA    = 5'h0E;
  localparam logic [4:0] FS_LUI    = 5'h0F;

  // MDU function codes
  localparam logic [4:0] FS_MULT   = 5'h10;
  localparam logic [4:0] FS_MULTU  = 5'h11;
  localparam logic [4:0] FS_DIV    = 5'h12;
  localparam logic [4:0] FS_DIVU   = 5'h13;

  // Y output mux
  localparam logic [2:0] Y_ALU = 3'd0;
  localparam logic [2:0] Y_HI  = 3'd1;
  localparam logic [2:0] Y_LO  = 3'd2;
  localparam logic [2:0] Y_DIN = 3'd3;
  localparam logic [2:0] Y_PC  = 3'd4;

  // Destination address mux
  localparam logic [1:0] DA_D  = 2'd0;
  localparam logic [1:0] DA_T  = 2'd1;
  localparam logic [1:0] DA_RA = 2'd2;
  localparam logic [1:0] DA_SP = 2'd3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_md_op(input logic [4:0] fs);
    return (fs == FS_MULT) || (fs == FS_MULTU) || (fs == FS_DIV) || (fs == FS_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit.
// Operands are reduced to magnitudes at start, processed one bit per cycle
// (shift-add multiply or restoring divide), then sign-corrected into HI/LO.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start, fs       start request and function select (MULT/MULTU/DIV/DIVU)
//   rs, rt          operands (sampled on an accepted start)
//   busy            operation in progress (RUN or FIX)
//   done            one-cycle pulse after HI/LO are written
//   hi, lo          result registers
module mdu_iter
  import idp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        fs,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W + 1);

  mdu_state_t state, state_nxt;

  logic [CW-1:0]     count;
  logic              is_div, neg_lo, neg_hi, div0;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;   // |rt|: multiplicand or divisor magnitude
  logic [DATA_W:0]   acc;       // product high half / partial remainder
  logic [DATA_W-1:0] q;         // multiplier bits / quotient bits

  logic              accept, op_signed, op_div, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign accept    = (state == MDU_IDLE) && start && is_md_op(fs);
  assign op_signed = (fs == FS_MULT) || (fs == FS_DIV);
  assign op_div    = (fs == FS_DIV) || (fs == FS_DIVU);
  assign a_neg     = op_signed && rs[DATA_W-1];
  assign b_neg     = op_signed && rt[DATA_W-1];
  assign a_mag     = a_neg ? -rs : rs;
  assign b_mag     = b_neg ? -rt : rt;
  assign busy      = (state != MDU_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (accept) state_nxt = MDU_RUN;
      MDU_RUN:  if (count == CW'(1)) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  // One iteration step
  logic [DATA_W:0]   add_sum, shifted, trial, acc_step;
  logic [DATA_W-1:0] q_step;

  always_comb begin
    add_sum  = '0;
    shifted  = '0;
    trial    = '0;
    acc_step = acc;
    q_step   = q;
    if (is_div) begin
      shifted = {acc[DATA_W-1:0], q[DATA_W-1]};
      trial   = shifted - {1'b0, divisor};
      // Remainder stays below divisor, so bit DATA_W of trial is a pure sign bit
      if (!trial[DATA_W]) begin
        acc_step = trial;
        q_step   = {q[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = shifted;
        q_step   = {q[DATA_W-2:0], 1'b0};
      end
    end else begin
      add_sum  = q[0] ? (acc + {1'b0, divisor}) : acc;
      acc_step = {1'b0, add_sum[DATA_W:1]};
      q_step   = {add_sum[0], q[DATA_W-1:1]};
    end
  end

  // Sign fixup
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  always_comb begin
    prod     = {acc[DATA_W-1:0], q};
    prod_fix = neg_lo ? -prod : prod;
    quo_fix  = neg_lo ? -q : q;
    rem_fix  = neg_hi ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div0     <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      acc      <= '0;
      q        <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            count    <= CW'(DATA_W);
            is_div   <= op_div;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= op_div && a_neg;
            div0     <= op_div && (rt == '0);
            dividend <= rs;
            divisor  <= b_mag;
            acc      <= '0;
            q        <= a_mag;
          end
        end
        MDU_RUN: begin
          acc   <= acc_step;
          q     <= q_step;
          count <= count - CW'(1);
        end
        MDU_FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (div0) begin
            hi <= dividend;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/idp_mdu_gen2.sv
// Gen2 integer datapath: register file (R0 = 0), RS/RT/ALU_out/D_in scratch
// registers, DA/T/Y muxes, combinational ALU and an iterative MDU for HI/LO.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   D_En, DA_Sel                regfile write enable / destination select
//   T_Sel, Y_Sel, FS, shamt     RT source, output select, function, shift amount
//   D_Addr, S_Addr, T_Addr      register addresses
//   DT, DY, pc_in               immediate, memory read data, PC
//   md_start, md_busy, md_done  MDU handshake
//   C, V, N, Z                  ALU flags
//   ALU_OUT, D_OUT              Y-mux output, RT
module idp_mdu_gen2
  import idp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5,
  parameter int RA_IDX = 2**RF_AW - 1,
  parameter int SP_IDX = 2**RF_AW - 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              D_En,
  input  logic [1:0]        DA_Sel,
  input  logic              T_Sel,
  input  logic [2:0]        Y_Sel,
  input  logic [4:0]        FS,
  input  logic [4:0]        shamt,
  input  logic [RF_AW-1:0]  D_Addr,
  input  logic [RF_AW-1:0]  S_Addr,
  input  logic [RF_AW-1:0]  T_Addr,
  input  logic [DATA_W-1:0] DT,
  input  logic [DATA_W-1:0] DY,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic              C,
  output logic              V,
  output logic              N,
  output logic              Z,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic [DATA_W-1:0] D_OUT
);

  localparam int DEPTH = 2**RF_AW;
  localparam int SHW   = $clog2(DATA_W);
  localparam int MSB   = DATA_W - 1;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] s_val, t_val, rs, rt, alu_out_q, d_in, alu_res, hi, lo;
  logic [RF_AW-1:0]  wr_addr;
  logic [SHW-1:0]    sh;

  // Register file
  assign s_val = (S_Addr == '0) ? '0 : rf[S_Addr];
  assign t_val = (T_Addr == '0) ? '0 : rf[T_Addr];

  always_comb begin
    wr_addr = D_Addr;
    case (DA_Sel)
      DA_D:    wr_addr = D_Addr;
      DA_T:    wr_addr = T_Addr;
      DA_RA:   wr_addr = RF_AW'(RA_IDX);
      DA_SP:   wr_addr = RF_AW'(SP_IDX);
      default: wr_addr = D_Addr;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[RF_AW'(i)] <= '0;
    end else if (D_En && (wr_addr != '0)) begin
      rf[wr_addr] <= ALU_OUT;
    end
  end

  // Scratch registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs        <= '0;
      rt        <= '0;
      alu_out_q <= '0;
      d_in      <= '0;
    end else begin
      rs        <= s_val;
      rt        <= T_Sel ? DT : t_val;
      alu_out_q <= alu_res;
      d_in      <= DY;
    end
  end

  // ALU
  logic [DATA_W:0] sum;
  logic            c_f, v_f;

  assign sh = shamt[SHW-1:0];

  always_comb begin
    alu_res = '0;
    sum     = '0;
    c_f     = 1'b0;
    v_f     = 1'b0;
    case (FS)
      FS_PASS_S: alu_res = rs;
      FS_PASS_T: alu_res = rt;
      FS_ADD, FS_ADDU: begin
        sum     = {1'b0, rs} + {1'b0, rt};
        alu_res = sum[MSB:0];
        c_f     = sum[DATA_W];
        v_f     = (rs[MSB] == rt[MSB]) && (alu_res[MSB] != rs[MSB]);
      end
      FS_SUB, FS_SUBU: begin
        // Carry out of rs + ~rt + 1, i.e. C=1 means no borrow
        sum     = {1'b0, rs} + {1'b0, ~rt} + (DATA_W+1)'(1);
        alu_res = sum[MSB:0];
        c_f     = sum[DATA_W];
        v_f     = (rs[MSB] != rt[MSB]) && (alu_res[MSB] != rs[MSB]);
      end
      FS_SLT:  alu_res = DATA_W'($signed(rs) < $signed(rt));
      FS_SLTU: alu_res = DATA_W'(rs < rt);
      FS_AND:  alu_res = rs & rt;
      FS_OR:   alu_res = rs | rt;
      FS_XOR:  alu_res = rs ^ rt;
      FS_NOR:  alu_res = ~(rs | rt);
      FS_SLL:  alu_res = rt << sh;
      FS_SRL:  alu_res = rt >> sh;
      FS_SRA:  alu_res = DATA_W'($signed(rt) >>> sh);
      FS_LUI:  alu_res = rt << (DATA_W / 2);
      default: alu_res = '0;
    endcase
  end

  assign C = c_f;
  assign V = v_f;
  assign N = alu_res[MSB];
  assign Z = (alu_res == '0);

  // MDU
  mdu_iter #(.DATA_W(DATA_W)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .fs    (FS),
    .rs    (rs),
    .rt    (rt),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo)
  );

  // Output muxes
  always_comb begin
    ALU_OUT = alu_out_q;
    case (Y_Sel)
      Y_ALU:   ALU_OUT = alu_out_q;
      Y_HI:    ALU_OUT = hi;
      Y_LO:    ALU_OUT = lo;
      Y_DIN:   ALU_OUT = d_in;
      Y_PC:    ALU_OUT = pc_in;
      default: ALU_OUT = alu_out_q;
    endcase
  end

  assign D_OUT = rt;

endmodule

// File: tb/tb_idp_mdu_gen2.sv
// Directed self-checking bench for idp_mdu_gen2 (default build plus an
// RF_AW=4 build driven with the low address bits of the same stimulus).
module tb_idp_mdu_gen2;
  import idp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_En;
  logic [1:0]  DA_Sel;
  logic        T_Sel;
  logic [2:0]  Y_Sel;
  logic [4:0]  FS;
  logic [4:0]  shamt;
  logic [4:0]  D_Addr, S_Addr, T_Addr;
  logic [31:0] DT, DY, pc_in;
  logic        md_start;

  logic        md_busy, md_done, C, V, N, Z;
  logic [31:0] ALU_OUT, D_OUT;
  logic        b_busy, b_done, b_C, b_V, b_N, b_Z;
  logic [31:0] b_alu_out, b_d_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idp_mdu_gen2 dut (
    .clk(clk), .reset(reset), .D_En(D_En), .DA_Sel(DA_Sel), .T_Sel(T_Sel),
    .Y_Sel(Y_Sel), .FS(FS), .shamt(shamt), .D_Addr(D_Addr), .S_Addr(S_Addr),
    .T_Addr(T_Addr), .DT(DT), .DY(DY), .pc_in(pc_in), .md_start(md_start),
    .md_busy(md_busy), .md_done(md_done), .C(C), .V(V), .N(N), .Z(Z),
    .ALU_OUT(ALU_OUT), .D_OUT(D_OUT)
  );

  idp_mdu_gen2 #(.RF_AW(4)) dut_aw4 (
    .clk(clk), .reset(reset), .D_En(D_En), .DA_Sel(DA_Sel), .T_Sel(T_Sel),
    .Y_Sel(Y_Sel), .FS(FS), .shamt(shamt), .D_Addr(D_Addr[3:0]), .S_Addr(S_Addr[3:0]),
    .T_Addr(T_Addr[3:0]), .DT(DT), .DY(DY), .pc_in(pc_in), .md_start(md_start),
    .md_busy(b_busy), .md_done(b_done), .C(b_C), .V(b_V), .N(b_N), .Z(b_Z),
    .ALU_OUT(b_alu_out), .D_OUT(b_d_out)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [1:0] sel, input logic [31:0] val);
    D_Addr = addr; DA_Sel = sel; Y_Sel = Y_PC; pc_in = val; D_En = 1'b1;
    tick();
    D_En = 1'b0;
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
    wr_reg(5'd1, DA_D, a);
    S_Addr = 5'd1; T_Sel = 1'b1; DT = b;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; D_En = 0; DA_Sel = 0; T_Sel = 0; Y_Sel = 0; FS = 0; shamt = 0;
    D_Addr = 0; S_Addr = 0; T_Addr = 0; DT = 0; DY = 0; pc_in = 0; md_start = 0;
    tick(); tick();
    reset = 1'b0;
    Y_Sel = Y_HI; #1; checks++;
    if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", ALU_OUT, 32'h0); end
    Y_Sel = Y_LO; #1; checks++;
    if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", ALU_OUT, 32'h0); end
    Y_Sel = Y_ALU; #1; checks++;
    if (ALU_OUT !== 32'h0 || D_OUT !== 32'h0) begin errors++; $display("FAIL reset_scratch: got alu=%h d=%h expected 0/0", ALU_OUT, D_OUT); end
    checks++;
    if ({md_busy, md_done, Z} !== 3'b001) begin errors++; $display("FAIL reset_mdu: got busy/done/Z=%b expected 001", {md_busy, md_done, Z}); end
  endtask

  task automatic test_regfile();
    T_Sel = 1'b0;
    wr_reg(5'd0, DA_D, 32'hDEADBEEF);
    T_Addr = 5'd0; tick(); checks++;
    if (D_OUT !== 32'h0) begin errors++; $display("FAIL r0_zero: got %h expected %h", D_OUT, 32'h0); end

    wr_reg(5'd5, DA_D, 32'h11111111);
    D_Addr = 5'd5; DA_Sel = DA_D; Y_Sel = Y_PC; pc_in = 32'h22222222; D_En = 1'b1; T_Addr = 5'd5;
    tick(); D_En = 1'b0; checks++;
    if (D_OUT !== 32'h11111111) begin errors++; $display("FAIL rd_old_on_wr: got %h expected %h", D_OUT, 32'h11111111); end
    tick(); checks++;
    if (D_OUT !== 32'h22222222) begin errors++; $display("FAIL rd_after_wr: got %h expected %h", D_OUT, 32'h22222222); end

    T_Addr = 5'd7; D_Addr = 5'd3;
    wr_reg(5'd3, DA_T, 32'h00000077);
    tick(); checks++;
    if (D_OUT !== 32'h77) begin errors++; $display("FAIL dasel_t: got %h expected %h", D_OUT, 32'h77); end

    wr_reg(5'd0, DA_RA, 32'hA5A5A5A5);
    wr_reg(5'd0, DA_SP, 32'h5A5A5A5A);
    T_Addr = 5'd31; tick(); checks++;
    if (D_OUT !== 32'hA5A5A5A5 || b_d_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL ra_write: got %h/%h expected %h", D_OUT, b_d_out, 32'hA5A5A5A5); end
    T_Addr = 5'd29; tick(); checks++;
    if (D_OUT !== 32'h5A5A5A5A || b_d_out !== 32'h5A5A5A5A) begin errors++; $display("FAIL sp_write: got %h/%h expected %h", D_OUT, b_d_out, 32'h5A5A5A5A); end
    T_Addr = 5'd15; tick(); checks++;
    if (D_OUT !== 32'h0) begin errors++; $display("FAIL ra_not_r15_aw5: got %h expected %h", D_OUT, 32'h0); end
  endtask

  typedef struct packed {
    logic [4:0]  fs;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic [3:0]  cvnz;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t v [12];
    v[0]  = '{FS_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 4'b0110};
    v[1]  = '{FS_SUBU, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF, 4'b0010};
    v[2]  = '{FS_SRA,  32'h00000000, 32'h80000000, 5'd4, 32'hF8000000, 4'b0010};
    v[3]  = '{FS_ADDU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 4'b1001};
    v[4]  = '{FS_SUB,  32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 4'b1001};
    v[5]  = '{FS_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 4'b0000};
    v[6]  = '{FS_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 4'b0001};
    v[7]  = '{FS_LUI,  32'h00000000, 32'h00001234, 5'd0, 32'h12340000, 4'b0000};
    v[8]  = '{FS_NOR,  32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 4'b0010};
    v[9]  = '{FS_SRL,  32'h00000000, 32'h80000000, 5'd4, 32'h08000000, 4'b0000};
    v[10] = '{FS_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 4'b0000};
    v[11] = '{FS_SUB,  32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 4'b1100};
    for (int i = 0; i < 12; i++) begin
      load_ops(v[i].a, v[i].b);
      FS = v[i].fs; shamt = v[i].sh; Y_Sel = Y_ALU;
      #1; checks++;
      if ({C, V, N, Z} !== v[i].cvnz || {b_C, b_V, b_N, b_Z} !== v[i].cvnz) begin
        errors++;
        $display("FAIL alu_flags[%0d]: got CVNZ=%b/%b expected %b", i, {C, V, N, Z}, {b_C, b_V, b_N, b_Z}, v[i].cvnz);
      end
      tick(); checks++;
      if (ALU_OUT !== v[i].res) begin errors++; $display("FAIL alu_res[%0d]: got %h expected %h", i, ALU_OUT, v[i].res); end
    end
    shamt = 0;
  endtask

  task automatic test_mult();
    int n = 0;
    int busy_cnt = 0;
    load_ops(32'hFFFFFFFD, 32'h00000005);
    FS = FS_MULT; md_start = 1'b1; tick(); md_start = 1'b0;
    while (md_done !== 1'b1 && n < 100) begin
      if (md_busy) busy_cnt++;
      tick(); n++;
    end
    checks++;
    if (n != 33) begin errors++; $display("FAIL mult_latency: got %0d edges expected 33", n); end
    checks++;
    if (busy_cnt != 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", busy_cnt); end
    checks++;
    if (b_done !== 1'b1) begin errors++; $display("FAIL mult_done_aw4: got %b expected 1", b_done); end
    Y_Sel = Y_HI; #1; checks++;
    if (ALU_OUT !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", ALU_OUT, 32'hFFFFFFFF); end
    Y_Sel = Y_LO; #1; checks++;
    if (ALU_OUT !== 32'hFFFFFFF1 || b_alu_out !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo: got %h/%h expected %h", ALU_OUT, b_alu_out, 32'hFFFFFFF1); end
    tick(); checks++;
    if (md_done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", md_done); end
  endtask

  typedef struct packed {
    logic [4:0]  fs;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_vec_t;

  task automatic test_div();
    md_vec_t v [4];
    v[0] = '{FS_DIVU, 32'd100,        32'd7,        32'd2,        32'd14};
    v[1] = '{FS_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[2] = '{FS_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[3] = '{FS_DIV,  32'd1234,       32'd0,        32'd1234,     32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      load_ops(v[i].a, v[i].b);
      FS = v[i].fs; md_start = 1'b1; tick(); md_start = 1'b0;
      while (md_done !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (n != 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d edges expected 33", i, n); end
      Y_Sel = Y_HI; #1; checks++;
      if (ALU_OUT !== v[i].hi) begin errors++; $display("FAIL div_hi[%0d]: got %h expected %h", i, ALU_OUT, v[i].hi); end
      Y_Sel = Y_LO; #1; checks++;
      if (ALU_OUT !== v[i].lo) begin errors++; $display("FAIL div_lo[%0d]: got %h expected %h", i, ALU_OUT, v[i].lo); end
    end
  endtask

  // Expects HI=1234, LO=all ones left from the divide-by-zero case.
  task automatic test_busy_ignore();
    int done_cnt = 0;
    load_ops(32'd1000, 32'd10);
    FS = FS_DIVU; md_start = 1'b1; tick(); md_start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 10) begin
        Y_Sel = Y_LO; #1; checks++;
        if (ALU_OUT !== 32'hFFFFFFFF) begin errors++; $display("FAIL lo_stale_while_busy: got %h expected %h", ALU_OUT, 32'hFFFFFFFF); end
        Y_Sel = Y_HI; #1; checks++;
        if (ALU_OUT !== 32'd1234) begin errors++; $display("FAIL hi_stale_while_busy: got %h expected %h", ALU_OUT, 32'd1234); end
        FS = FS_MULTU; md_start = 1'b1;
      end
      if (i == 11) begin md_start = 1'b0; FS = FS_DIVU; end
      if (md_done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
    Y_Sel = Y_LO; #1; checks++;
    if (ALU_OUT !== 32'd100) begin errors++; $display("FAIL busy_start_lo: got %h expected %h", ALU_OUT, 32'd100); end
    Y_Sel = Y_HI; #1; checks++;
    if (ALU_OUT !== 32'd0) begin errors++; $display("FAIL busy_start_hi: got %h expected %h", ALU_OUT, 32'd0); end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    int n = 0;
    load_ops(32'h12345678, 32'h9ABCDEF0);
    FS = FS_MULTU; md_start = 1'b1; tick(); md_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1; #1; checks++;
    if (md_busy !== 1'b0 || b_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got busy=%b/%b done=%b expected 0/0/0", md_busy, b_busy, md_done); end
    Y_Sel = Y_HI; #1; checks++;
    if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL reset_mid_hi: got %h expected %h", ALU_OUT, 32'h0); end
    Y_Sel = Y_LO; #1; checks++;
    if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL reset_mid_lo: got %h expected %h", ALU_OUT, 32'h0); end
    tick(); reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (md_done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d expected 0", done_cnt); end

    load_ops(32'hFFFFFFFF, 32'hFFFFFFFF);
    FS = FS_MULTU; md_start = 1'b1; tick(); md_start = 1'b0;
    while (md_done !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != 33) begin errors++; $display("FAIL multu_latency: got %0d edges expected 33", n); end
    Y_Sel = Y_HI; #1; checks++;
    if (ALU_OUT !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", ALU_OUT, 32'hFFFFFFFE); end
    Y_Sel = Y_LO; #1; checks++;
    if (ALU_OUT !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h expected %h", ALU_OUT, 32'h00000001); end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_alu();
    test_mult();
    test_div();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
